// File: rtl/gcd_lcm_seq.sv
// gcd_lcm_seq: sequential GCD / LCM engine for the RSA key-generation datapath.
// The GCD is computed with Stein's binary algorithm and a shared power-of-two
// count. LCM = (a / g) * b uses a restoring divider and a shift-add multiplier.
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous reset, active-high (priority over start)
//   start    begin an operation; accepted only when idle
//   mode     0 = GCD only, 1 = GCD and LCM (latched at start)
//   ina/inb  operands a and b (latched at start)
//   busy     high from the cycle after start is accepted until done
//   done     one-cycle pulse when gcd_out/lcm_out become valid
//   gcd_out  gcd(a, b), held until the next completed operation
//   lcm_out  lcm(a, b) when mode=1, else 0, held likewise
module gcd_lcm_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               mode,
  input  logic [WIDTH-1:0]   ina,
  input  logic [WIDTH-1:0]   inb,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   gcd_out,
  output logic [2*WIDTH-1:0] lcm_out
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GCD,
    S_DIV,
    S_MUL,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  // a_q is the GCD working value, then the dividend/quotient, then the multiplier
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] a0_q, a0_d;
  logic [WIDTH-1:0] b0_q, b0_d;
  logic [SHW-1:0]   k_q, k_d;
  logic             mode_q, mode_d;
  logic [WIDTH-1:0] g_q, g_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [PW-1:0]    prod_q, prod_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] gcd_q, gcd_d;
  logic [PW-1:0]    lcm_q, lcm_d;

  logic [WIDTH:0]   rem_sh;
  logic [PW-1:0]    prod_nx;

  // Next-state and datapath logic
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    a0_d    = a0_q;
    b0_d    = b0_q;
    k_d     = k_q;
    mode_d  = mode_q;
    g_d     = g_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    mcand_d = mcand_q;
    prod_d  = prod_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    gcd_d   = gcd_q;
    lcm_d   = lcm_q;
    rem_sh  = '0;
    prod_nx = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = ina;
          b_d     = inb;
          a0_d    = ina;
          b0_d    = inb;
          mode_d  = mode;
          k_d     = '0;
          busy_d  = 1'b1;
          state_d = S_GCD;
        end
      end

      S_GCD: begin
        // b can only be zero if it started at zero, so this also covers the zero-operand cases
        if ((a_q == '0) || (b_q == '0)) begin
          g_d = (a_q | b_q) << k_q;
          if (mode_q && (a0_q != '0) && (b0_q != '0)) begin
            a_d     = a0_q;
            rem_d   = '0;
            cnt_d   = '0;
            state_d = S_DIV;
          end else begin
            gcd_d   = (a_q | b_q) << k_q;
            lcm_d   = '0;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_DONE;
          end
        end else if (!a_q[0] && !b_q[0]) begin
          a_d = a_q >> 1;
          b_d = b_q >> 1;
          k_d = k_q + SHW'(1);
        end else if (!a_q[0]) begin
          a_d = a_q >> 1;
        end else if (!b_q[0]) begin
          b_d = b_q >> 1;
        end else if (a_q >= b_q) begin
          a_d = (a_q - b_q) >> 1;
        end else begin
          b_d = (b_q - a_q) >> 1;
        end
      end

      S_DIV: begin
        // Dividend bits leave a_q at the top while quotient bits enter at the bottom
        rem_sh = {rem_q, a_q[WIDTH-1]};
        if (rem_sh >= {1'b0, g_q}) begin
          rem_d = WIDTH'(rem_sh - {1'b0, g_q});
          a_d   = {a_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = rem_sh[WIDTH-1:0];
          a_d   = {a_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          cnt_d   = '0;
          prod_d  = '0;
          mcand_d = PW'(b0_q);
          state_d = S_MUL;
        end
      end

      S_MUL: begin
        prod_nx = prod_q + (a_q[0] ? mcand_q : '0);
        prod_d  = prod_nx;
        mcand_d = mcand_q << 1;
        a_d     = a_q >> 1;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          gcd_d   = g_q;
          lcm_d   = prod_nx;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      a0_q    <= '0;
      b0_q    <= '0;
      k_q     <= '0;
      mode_q  <= 1'b0;
      g_q     <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      mcand_q <= '0;
      prod_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      gcd_q   <= '0;
      lcm_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      a0_q    <= a0_d;
      b0_q    <= b0_d;
      k_q     <= k_d;
      mode_q  <= mode_d;
      g_q     <= g_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      gcd_q   <= gcd_d;
      lcm_q   <= lcm_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign gcd_out = gcd_q;
  assign lcm_out = lcm_q;

endmodule

// File: doc/gcd_lcm_seq.md
Name: gcd_lcm_seq

Overview:
- Parametrised sequential GCD/LCM engine for the RSA key-generation datapath. Used for the gcd(e, phi) coprimality check and for lcm(p-1, q-1).
- GCD uses the binary (Stein) algorithm with a tracked common power-of-two shift count, so no multiplier is needed for the GCD result.
- LCM is computed as (a / g) * b using an internal restoring divider and a shift-add multiplier.
- Start/done handshake; operands are latched at start.

Parameters:
- WIDTH, 32, operand and GCD width in bits (>= 4).
- SHW, $clog2(WIDTH)+1, width of the common-factor shift counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- start  input  1  pulse to begin an operation; accepted only in IDLE.
- mode  input  1  0 = GCD only, 1 = GCD and LCM; latched at start.
- ina  input  WIDTH  operand a; latched at start.
- inb  input  WIDTH  operand b; latched at start.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse when results become valid.
- gcd_out  output  WIDTH  gcd(a, b); held until the next accepted start.
- lcm_out  output  2*WIDTH  lcm(a, b) when mode=1; 0 when mode=0; held.

Behaviour:
- Reset: state=IDLE; busy=0, done=0, gcd_out=0, lcm_out=0; all internal registers cleared.
  - Reset mid-operation aborts immediately.
  - rst has priority over start in the same cycle.
- Start handling:
  - IDLE + start=1: latch a, b, mode and keep copies a0, b0. Set k=0 and busy=1; next state GCD.
  - start while busy=1 is ignored.
- Zero cases, resolved in the first GCD cycle:
  - a0=0: g=b0.
  - b0=0: g=a0.
  - Both zero: g=0.
  - Any zero operand: lcm=0, skip DIV/MUL, go to DONE.
- GCD state, one step per cycle, in priority order:
  - a==0: g = b << k, go to DIV if mode=1, else DONE.
  - a even, b even: a>>=1, b>>=1, k+=1.
  - a even, b odd: a>>=1.
  - a odd, b even: b>>=1.
  - Both odd, a>=b: a = (a-b)>>1.
  - Both odd, a<b: b = (b-a)>>1.
  - Worst-case steps: <= 2*WIDTH+2.
- DIV state: restoring division q = a0 / g.
  - Exactly WIDTH cycles, one quotient bit per cycle, MSB first.
  - Remainder is guaranteed 0 and is not checked.
- MUL state: shift-add product lcm = q * b0.
  - Exactly WIDTH cycles, one multiplier bit per cycle, LSB first.
  - Product width 2*WIDTH, with no overflow possible.
- DONE state (one cycle):
  - Register gcd_out=g and lcm_out=(mode ? product : 0).
  - done=1 and busy=0 in this same cycle; next state IDLE.
  - done deasserts the following cycle.
  - start is accepted in the cycle after DONE, with no dead cycle beyond it.
- Outputs change only in DONE or on reset.
- All arithmetic is unsigned. Subtractions are performed only when the minuend >= the subtrahend.
- Total latency, mode=1: GCD steps + 2*WIDTH + 1 cycles from start to done.

Test Plan:
- WIDTH=32, mode=0, ina=48, inb=18, start pulse -> done within 66 cycles; gcd_out=6, lcm_out=0; busy high throughout.
- WIDTH=32, mode=1, ina=3120 (p-1=40*78), inb=65537 -> gcd_out=1, lcm_out=204475440.
- WIDTH=32, mode=1, ina=0xFFFFFFFF, inb=0xFFFFFFFE -> gcd_out=1, lcm_out=0xFFFFFFFD00000002. Checks the full-width product.
- Zero operands, mode=1:
  - ina=0, inb=77 -> gcd_out=77, lcm_out=0.
  - ina=77, inb=0 -> gcd_out=77, lcm_out=0.
  - ina=0, inb=0 -> gcd_out=0, lcm_out=0.
  - Each completes in <= 3 cycles.
- Mid-operation control, WIDTH=8:
  - Start 200/150 with mode=1; pulse start again in cycles 2-5 -> ignored; result gcd=50, lcm=600.
  - Repeat, and assert rst during MUL -> busy=0, done never pulses, outputs=0.
  - Then start 12/8 -> gcd=4, lcm=24.
- Random regression, WIDTH=16: 1000 random pairs in both modes vs. a reference model. Checks back-to-back starts in the cycle after done and that done is exactly one cycle wide.
